cam_array_ctrl: RTL and testbench

Parametrised, clocked content-addressable word array for the associative processor. It holds WORDS words of WIDTH bits each and a tag register with one bit per word. It executes one command per handshake: masked parallel search (replace, AND and OR modes), masked parallel write to all tagged words, addressed write, tag select/set, and first-responder readout. It sits between the sequencer (command side) and the result collector (response side).

---
 rtl/cam_pkg.sv | 17 +
 rtl/cam_first_one.sv | 30 +++
 rtl/cam_array_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cam_array_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared opcode encoding for the associative word array.
package cam_pkg;

    localparam int CAM_OP_W = 3;

    typedef enum logic [CAM_OP_W-1:0] {
        OP_READ         = 3'd0,
        OP_SEARCH       = 3'd1,
        OP_SEARCH_AND   = 3'd2,
        OP_SEARCH_OR    = 3'd3,
        OP_WRITE_TAGGED = 3'd4,
        OP_WRITE_ADDR   = 3'd5,
        OP_SELECT_FIRST = 3'd6,
        OP_SET_TAGS     = 3'd7
    } cam_op_e;

endpackage

// File: rtl/cam_first_one.sv
// cam_first_one: combinational lowest-set-bit finder.
// Reports whether any bit is set, the index of the lowest set bit and the
// same position as a one-hot vector. All outputs are zero for an empty input.
module cam_first_one #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic          any_o,
    output logic [IW-1:0] index_o,
    output logic [N-1:0]  onehot_o
);

    assign any_o    = |vec_i;
    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = vec_i & (~vec_i + N'(1));

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: combinational logic uses blocking '='; ordered overwrites inside
        // one evaluation are what give the scan its priority.
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                index_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cam_array_ctrl.sv
// cam_array_ctrl: content-addressable word array with a per-word tag register.
// One command per handshake; one registered response per accepted command.
// Optional feature: define CAM_RESP_COUNT_EN to add the resp_count output
// (popcount of the post-op tags), registered with the other response fields.
module cam_array_ctrl
    import cam_pkg::*;
#(
    parameter int WORDS = 100,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CAM_OP_W-1:0]   cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic [WIDTH-1:0]      cmd_mask,
    input  logic [AW-1:0]         cmd_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [AW-1:0]         resp_index,
    output logic [WIDTH-1:0]      resp_data,
    output logic [WORDS-1:0]      tags
`ifdef CAM_RESP_COUNT_EN
    ,
    output logic [$clog2(WORDS+1)-1:0] resp_count
`endif
);

    logic [WIDTH-1:0] store_q [WORDS];
    logic [WIDTH-1:0] store_d [WORDS];
    logic [WORDS-1:0] tags_q, tags_d;
    logic [WORDS-1:0] match;
    logic             accept;

    logic             resp_valid_q, resp_hit_q;
    logic [AW-1:0]    resp_index_q;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;

    logic             sel_any, rsp_any;
    logic [AW-1:0]    sel_index, rsp_index;
    logic [WORDS-1:0] sel_onehot, rsp_onehot;
    logic             unused_ok;

    // Single-entry output register: a new command may enter whenever the
    // current response leaves in the same cycle.
    assign cmd_ready = !resp_valid_q || resp_ready;
    assign accept    = cmd_valid && cmd_ready;

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] new_w,
                                               input logic [WIDTH-1:0] mask);
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Lowest tagged word of the current tags, used by OP_SELECT_FIRST.
    cam_first_one #(.N(WORDS), .IW(AW)) u_sel_first (
        .vec_i    (tags_q),
        .any_o    (sel_any),
        .index_o  (sel_index),
        .onehot_o (sel_onehot)
    );

    // Lowest tagged word of the post-op tags, reported in the response.
    cam_first_one #(.N(WORDS), .IW(AW)) u_rsp_first (
        .vec_i    (tags_d),
        .any_o    (rsp_any),
        .index_o  (rsp_index),
        .onehot_o (rsp_onehot)
    );

    assign unused_ok = ^{sel_any, sel_index, rsp_onehot};

    // Parallel masked compare of every stored word against the comparand.
    always_comb begin
        match = '0;
        for (int i = 0; i < WORDS; i++) begin
            match[i] = ((store_q[i] ^ cmd_data) & cmd_mask) == '0;
        end
    end

    // Next-state store and tags for the accepted command.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path through
        // this block can leave a value unassigned and infer a latch.
        tags_d = tags_q;
        for (int i = 0; i < WORDS; i++) begin
            store_d[i] = store_q[i];
        end
        if (accept) begin
            unique case (cam_op_e'(cmd_op))
                OP_READ:         ;
                OP_SEARCH:       tags_d = match;
                OP_SEARCH_AND:   tags_d = tags_q & match;
                OP_SEARCH_OR:    tags_d = tags_q | match;
                OP_WRITE_TAGGED: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (tags_q[i]) begin
                            store_d[i] = merge(store_q[i], cmd_data, cmd_mask);
                        end
                    end
                end
                OP_WRITE_ADDR: begin
                    // Out-of-range addresses are silently ignored.
                    if (int'(cmd_addr) < WORDS) begin
                        store_d[cmd_addr] = merge(store_q[cmd_addr], cmd_data, cmd_mask);
                    end
                end
                OP_SELECT_FIRST: tags_d = sel_onehot;
                OP_SET_TAGS:     tags_d = '1;
                default:         ;
            endcase
        end
    end

    // Response data comes from the post-op store so this op's writes show up.
    always_comb begin
        resp_data_d = '0;
        if (rsp_any) begin
            resp_data_d = store_d[rsp_index];
        end
    end

    // Array state registers; the whole store clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the store is a register array, not a RAM macro, so it can
            // and must be reset here to give the all-zero starting contents.
            for (int i = 0; i < WORDS; i++) begin
                store_q[i] <= '0;
            end
            tags_q <= '0;
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                store_q[i] <= store_d[i];
            end
            tags_q <= tags_d;
        end
    end

    // Response register: load on accept, drop valid on consume, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
            resp_data_q  <= '0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= rsp_any;
            resp_index_q <= rsp_index;
            resp_data_q  <= resp_data_d;
        end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

`ifdef CAM_RESP_COUNT_EN
    localparam int CW = $clog2(WORDS + 1);
    logic [CW-1:0] count_d, count_q;

    // Population count of the post-op tags.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < WORDS; i++) begin
            count_d = count_d + CW'(tags_d[i]);
        end
    end

    // Count register, loaded alongside the other response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_d;
        end
    end

    assign resp_count = count_q;
`endif

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_index = resp_index_q;
    assign resp_data  = resp_data_q;
    assign tags       = tags_q;

endmodule

// File: tb/tb_cam_array_ctrl.sv
// tb_cam_array_ctrl: directed stimulus with a response scoreboard.
// The driver pushes the hand-computed response for each command into a queue;
// a monitor pops and compares whenever a response is consumed.
module tb_cam_array_ctrl;
    import cam_pkg::*;

    localparam int WORDS = 100;
    localparam int WIDTH = 32;
    localparam int AW    = $clog2(WORDS);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [CAM_OP_W-1:0] cmd_op;
    logic [WIDTH-1:0]   cmd_data;
    logic [WIDTH-1:0]   cmd_mask;
    logic [AW-1:0]      cmd_addr;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_hit;
    logic [AW-1:0]      resp_index;
    logic [WIDTH-1:0]   resp_data;
    logic [WORDS-1:0]   tags;
`ifdef CAM_RESP_COUNT_EN
    logic [$clog2(WORDS+1)-1:0] resp_count;
`endif

    typedef struct {
        string            name;
        logic             hit;
        logic [AW-1:0]    idx;
        logic [WIDTH-1:0] data;
        logic [WORDS-1:0] tags;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [WORDS-1:0] T_NONE = '0;
    localparam logic [WORDS-1:0] T_ALL  = '1;
    localparam logic [WIDTH-1:0] M_ALL  = '1;

    cam_array_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_mask   (cmd_mask),
        .cmd_addr   (cmd_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_index (resp_index),
        .resp_data  (resp_data),
        .tags       (tags)
`ifdef CAM_RESP_COUNT_EN
        ,
        .resp_count (resp_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WORDS-1:0] t5(input logic [4:0] b);
        logic [WORDS-1:0] t;
        t      = '0;
        t[4:0] = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command, record its expected response, wait for acceptance.
    task automatic send(input cam_op_e op, input logic [WIDTH-1:0] data,
                        input logic [WIDTH-1:0] mask, input int addr, input string name,
                        input logic hit, input int idx, input logic [WIDTH-1:0] edata,
                        input logic [WORDS-1:0] etags);
        exp_t e;
        bit   ok;
        e.name = name; e.hit = hit; e.idx = AW'(idx); e.data = edata; e.tags = etags;
        cmd_op    = op;
        cmd_data  = data;
        cmd_mask  = mask;
        cmd_addr  = AW'(addr);
        cmd_valid = 1'b1;
        sb_q.push_back(e);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            failures++;
            checks++;
            $display("FAIL %s_accept: cmd_ready never seen, required 1", name);
        end
    endtask

    // Monitor: compare each consumed response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got response with empty scoreboard, required none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, ".hit"},   resp_hit,   e.hit);
                check({e.name, ".index"}, resp_index, e.idx);
                check({e.name, ".data"},  resp_data,  e.data);
                check({e.name, ".tags"},  tags,       e.tags);
`ifdef CAM_RESP_COUNT_EN
                check({e.name, ".count"}, resp_count, $countones(e.tags));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_mask = '0;
        cmd_addr = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst.resp_valid", resp_valid, 1'b0);
        check("rst.cmd_ready",  cmd_ready,  1'b1);
        check("rst.tags",       tags,       T_NONE);
        check("rst.resp_hit",   resp_hit,   1'b0);
        check("rst.resp_index", resp_index, '0);
        check("rst.resp_data",  resp_data,  '0);
        @(posedge clk); #1;

        // Load words 0..4; no tags set, so every response is empty.
        send(OP_WRITE_ADDR, 456,  M_ALL, 0, "wr0", 0, 0, 0, T_NONE);
        send(OP_WRITE_ADDR, 457,  M_ALL, 1, "wr1", 0, 0, 0, T_NONE);
        send(OP_WRITE_ADDR, 1000, M_ALL, 2, "wr2", 0, 0, 0, T_NONE);
        send(OP_WRITE_ADDR, 1000, M_ALL, 3, "wr3", 0, 0, 0, T_NONE);
        send(OP_WRITE_ADDR, 457,  M_ALL, 4, "wr4", 0, 0, 0, T_NONE);
        send(OP_READ,       0,    0,     0, "read0", 0, 0, 0, T_NONE);

        // Searches in the three modes.
        send(OP_SEARCH,     457,  M_ALL, 0, "srch457",  1, 1, 457,  t5(5'b10010));
        send(OP_SEARCH,     1000, M_ALL, 0, "srch1000", 1, 2, 1000, t5(5'b01100));
        send(OP_SEARCH_OR,  456,  M_ALL, 0, "or456",    1, 0, 456,  t5(5'b01101));
        send(OP_SEARCH_AND, 0,    1,     0, "and_even", 1, 0, 456,  t5(5'b01101));

        // Tagged write merges low byte: 0x1C9 -> 0x1AB in words 1 and 4.
        send(OP_SEARCH,       457,  M_ALL, 0, "srch457b", 1, 1, 457,   t5(5'b10010));
        send(OP_WRITE_TAGGED, 'hAB, 'hFF,  0, "wr_tag",   1, 1, 'h1AB, t5(5'b10010));
        send(OP_SELECT_FIRST, 0,    0,     0, "sel1",     1, 1, 'h1AB, t5(5'b00010));
        send(OP_SEARCH,       'h1AB, M_ALL, 0, "srch1ab", 1, 1, 'h1AB, t5(5'b10010));

        // Backpressure: response held, next command stalled for 5 cycles.
        send(OP_READ, 0, 0, 0, "bp_read", 1, 1, 'h1AB, t5(5'b10010));
        resp_ready = 1'b0;
        begin
            exp_t e;
            e.name = "wr_oob"; e.hit = 1'b1; e.idx = AW'(1); e.data = 'h1AB; e.tags = t5(5'b10010);
            cmd_op = OP_WRITE_ADDR; cmd_data = '1; cmd_mask = M_ALL; cmd_addr = AW'(WORDS);
            cmd_valid = 1'b1;
            sb_q.push_back(e);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp.cmd_ready",  cmd_ready,  1'b0);
            check("bp.resp_valid", resp_valid, 1'b1);
            check("bp.resp_hit",   resp_hit,   1'b1);
            check("bp.resp_index", resp_index, AW'(1));
            check("bp.resp_data",  resp_data,  32'h1AB);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp.release_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        // Out-of-range write must not have touched any word.
        send(OP_SEARCH,       '1, M_ALL, 0, "srch_ones", 0, 0, 0,   T_NONE);
        send(OP_SET_TAGS,     0,  0,     0, "set_all",   1, 0, 456, T_ALL);
        send(OP_SELECT_FIRST, 0,  0,     0, "sel0",      1, 0, 456, t5(5'b00001));
        send(OP_SELECT_FIRST, 0,  0,     0, "sel0_again", 1, 0, 456, t5(5'b00001));
        send(OP_SEARCH,       12345, M_ALL, 0, "srch_miss", 0, 0, 0, T_NONE);
        send(OP_SELECT_FIRST, 0,  0,     0, "sel_empty", 0, 0, 0,   T_NONE);

        // Reset with a response pending: it is dropped and the array cleared.
        send(OP_SET_TAGS, 0, 0, 0, "dropped", 1, 0, 456, T_ALL);
        resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst.resp_valid", resp_valid, 1'b0);
        check("midrst.tags",       tags,       T_NONE);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        send(OP_SET_TAGS, 0, 0, 0, "post_rst_set", 1, 0, 0, T_ALL);

        // Drain the scoreboard with a bounded wait.
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain.sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
